// File: rtl/key_scheduler_if.sv
// Bus bundle between a frame controller / pixel source / pixel sink and the key scheduler.
// Both pixel ports use valid/ready: a beat moves on a rising edge where valid and ready are both 1, and valid may not depend on ready.
interface key_scheduler_if;
    logic        start;
    logic [15:0] frame_len;
    logic        gen_rst;
    logic        key_valid;
    logic [7:0]  key_r;
    logic [7:0]  key_g;
    logic [7:0]  key_b;
    logic [23:0] pix_in;
    logic        pix_in_valid;
    logic        pix_in_ready;
    logic [23:0] pix_out;
    logic        pix_out_valid;
    logic        pix_out_ready;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output start, frame_len, key_valid, key_r, key_g, key_b,
               pix_in, pix_in_valid, pix_out_ready,
        input  gen_rst, pix_in_ready, pix_out, pix_out_valid, busy, done, err
    );

    modport slave (
        input  start, frame_len, key_valid, key_r, key_g, key_b,
               pix_in, pix_in_valid, pix_out_ready,
        output gen_rst, pix_in_ready, pix_out, pix_out_valid, busy, done, err
    );
endinterface

// File: rtl/key_scheduler.sv
// Reseeds a key generator per frame, discards warm-up keys, buffers key triples in a FIFO
// and XORs each incoming pixel with the next buffered triple in arrival order.
module key_scheduler #(
    parameter int FIFO_DEPTH  = 4,
    parameter int WARMUP_KEYS = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    key_scheduler_if.slave               bus,
    output logic [2:0]                   state_o,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] WARM_LAST = (WARMUP_KEYS > 0) ? 16'(WARMUP_KEYS - 1) : 16'd0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RESEED = 3'd1,
        WARMUP = 3'd2,
        RUN    = 3'd3,
        DRAIN  = 3'd4,
        ERR    = 3'd5
    } state_t;

    state_t      state_q;
    logic [23:0] mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic [15:0] remaining_q;
    logic [15:0] warm_cnt_q;
    logic        reseed_cnt_q;
    logic        gen_rst_q;
    logic        done_q;
    logic        err_q;
    logic        pix_out_valid_q;
    logic [23:0] pix_out_q;
    logic [23:0] pix_out_d;

    logic        fifo_empty;
    logic        fifo_full;
    logic        key_phase;
    logic        push;
    logic        overflow;
    logic        pix_in_ready;
    logic        xfer;
    logic        out_accept;
    logic        start_ok;
    logic [23:0] head;
    logic [23:0] key_word;

    // Full is judged on occupancy at the start of the cycle, so a same-cycle pop cannot rescue a push.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign key_phase  = (state_q == RUN) || (state_q == DRAIN);
    assign overflow   = key_phase && bus.key_valid && fifo_full;
    assign push       = key_phase && bus.key_valid && !fifo_full;
    assign head       = mem_q[rd_ptr_q[AW-1:0]];
    assign key_word   = {bus.key_r, bus.key_g, bus.key_b};

    assign pix_in_ready = (state_q == RUN) && !fifo_empty && (!pix_out_valid_q || bus.pix_out_ready);
    assign xfer         = bus.pix_in_valid && pix_in_ready;
    assign out_accept   = pix_out_valid_q && bus.pix_out_ready;
    assign pix_out_d    = bus.pix_in ^ head;
    assign start_ok     = bus.start && ((state_q == IDLE) || (state_q == ERR));

    assign bus.pix_in_ready  = pix_in_ready;
    assign bus.pix_out       = pix_out_q;
    assign bus.pix_out_valid = pix_out_valid_q;
    assign bus.gen_rst       = gen_rst_q;
    assign bus.done          = done_q;
    assign bus.err           = err_q;
    assign bus.busy          = (state_q != IDLE);
    assign state_o           = state_q;
    assign fifo_count_o      = wr_ptr_q - rd_ptr_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= key_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            remaining_q     <= '0;
            warm_cnt_q      <= '0;
            reseed_cnt_q    <= 1'b0;
            gen_rst_q       <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
            pix_out_valid_q <= 1'b0;
            pix_out_q       <= '0;
        end else begin
            done_q <= 1'b0;

            if (xfer) begin
                pix_out_q       <= pix_out_d;
                pix_out_valid_q <= 1'b1;
                rd_ptr_q        <= rd_ptr_q + 1'b1;
                if (remaining_q != 16'd0) begin
                    remaining_q <= remaining_q - 16'd1;
                end
            end else if (bus.pix_out_ready) begin
                pix_out_valid_q <= 1'b0;
            end

            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end

            case (state_q)
                IDLE, ERR: begin
                    if (start_ok) begin
                        remaining_q  <= bus.frame_len;
                        wr_ptr_q     <= '0;
                        rd_ptr_q     <= '0;
                        err_q        <= 1'b0;
                        warm_cnt_q   <= '0;
                        reseed_cnt_q <= 1'b0;
                        if (bus.frame_len == 16'd0) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            gen_rst_q <= 1'b1;
                            state_q   <= RESEED;
                        end
                    end
                end
                RESEED: begin
                    if (reseed_cnt_q) begin
                        gen_rst_q <= 1'b0;
                        state_q   <= (WARMUP_KEYS == 0) ? RUN : WARMUP;
                    end else begin
                        reseed_cnt_q <= 1'b1;
                    end
                end
                WARMUP: begin
                    if (bus.key_valid) begin
                        if (warm_cnt_q == WARM_LAST) begin
                            state_q <= RUN;
                        end else begin
                            warm_cnt_q <= warm_cnt_q + 16'd1;
                        end
                    end
                end
                RUN: begin
                    if (overflow) begin
                        err_q   <= 1'b1;
                        state_q <= ERR;
                    end else if (xfer && (remaining_q == 16'd1)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (overflow) begin
                        err_q   <= 1'b1;
                        state_q <= ERR;
                    end else if (out_accept) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_key_scheduler.sv
// Directed bench for key_scheduler: nominal frame, zero length, overflow under backpressure,
// recovery from ERR, simultaneous push/pop, ignored start and asynchronous reset.
module tb_key_scheduler;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RESEED = 3'd1;
  localparam logic [2:0] S_WARMUP = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_ERR    = 3'd5;
  localparam int WK = 2;

  logic clk;
  logic rst;
  logic [2:0] state_o;
  logic [2:0] fifo_count_o;
  int checks;
  int errors;
  logic [23:0] exp_q[$];

  logic [23:0] key_tab [16] = '{
    24'h1A2B3C, 24'h4D5E6F, 24'hA5C3F0, 24'h0F1E2D, 24'h3C4B5A,
    24'h697887, 24'h96A5B4, 24'hC3D2E1, 24'hF00FFF, 24'h123456,
    24'h789ABC, 24'hDEF012, 24'h55AA55, 24'hAA55AA, 24'h0000FF,
    24'hE7E7E7
  };
  logic [23:0] pix_tab [8] = '{
    24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h808080,
    24'h123ABC, 24'hFFFFFF, 24'h000000, 24'h5A5A5A
  };

  key_scheduler_if bus ();

  key_scheduler #(.FIFO_DEPTH(4), .WARMUP_KEYS(WK)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .state_o      (state_o),
    .fifo_count_o (fifo_count_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic set_key(input int idx);
    bus.key_r = key_tab[idx][23:16];
    bus.key_g = key_tab[idx][15:8];
    bus.key_b = key_tab[idx][7:0];
  endtask

  task automatic send_key(input int idx);
    bus.key_valid = 1'b1;
    set_key(idx);
    tick();
    bus.key_valid = 1'b0;
  endtask

  // Full frame with pix_out_ready=1, keys every 8 cycles from key_tab[kb], pixels always offered.
  task automatic run_frame(input int len, input int kb);
    int gcnt;
    int done_cnt;
    int p;
    int k;
    logic [23:0] exp;
    gcnt = 0;
    done_cnt = 0;
    p = 0;
    k = 0;
    bus.frame_len = 16'(len);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("start_err_clear", 32'(bus.err), 32'd0);
    check("start_fifo_flush", 32'(fifo_count_o), 32'd0);
    check("start_reseed", 32'(state_o), 32'(S_RESEED));
    repeat (2) begin
      if (bus.gen_rst) gcnt++;
      tick();
    end
    check("reseed_to_warmup", 32'(state_o), 32'(S_WARMUP));
    for (int cyc = 0; cyc < 8 * (WK + len) + 16; cyc++) begin
      if (bus.pix_out_valid) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
        check("frame_pix_out", 32'(bus.pix_out), 32'(exp));
      end
      if (bus.done) done_cnt++;
      if (bus.gen_rst) gcnt++;
      bus.key_valid = ((cyc % 8) == 0) && (k < WK + len);
      if (bus.key_valid) begin
        set_key(kb + k);
        k++;
      end
      bus.pix_in_valid = (p < len);
      bus.pix_in = (p < len) ? pix_tab[p] : 24'h0;
      #1;
      if (bus.pix_in_valid && bus.pix_in_ready) begin
        exp_q.push_back(pix_tab[p] ^ key_tab[kb + WK + p]);
        p++;
      end
      tick();
    end
    bus.key_valid = 1'b0;
    bus.pix_in_valid = 1'b0;
    check("gen_rst_two_cycles", 32'(gcnt), 32'd2);
    check("frame_pixels_sent", 32'(p), 32'(len));
    check("frame_outputs_seen", 32'(exp_q.size()), 32'd0);
    check("frame_done_once", 32'(done_cnt), 32'd1);
    check("frame_busy_low", 32'(bus.busy), 32'd0);
    check("frame_idle", 32'(state_o), 32'(S_IDLE));
    check("frame_no_err", 32'(bus.err), 32'd0);
  endtask

  initial begin
    logic [23:0] held;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.frame_len = 16'd0;
    bus.key_valid = 1'b0;
    bus.key_r = 8'd0;
    bus.key_g = 8'd0;
    bus.key_b = 8'd0;
    bus.pix_in = 24'd0;
    bus.pix_in_valid = 1'b0;
    bus.pix_out_ready = 1'b1;

    // reset state
    #3;
    check("rst_state", 32'(state_o), 32'(S_IDLE));
    check("rst_gen_rst", 32'(bus.gen_rst), 32'd0);
    check("rst_pix_in_ready", 32'(bus.pix_in_ready), 32'd0);
    check("rst_pix_out_valid", 32'(bus.pix_out_valid), 32'd0);
    check("rst_pix_out", 32'(bus.pix_out), 32'd0);
    check("rst_flags", 32'({bus.done, bus.err, bus.busy}), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // nominal frame: K0,K1 discarded, outputs P0^K2, P1^K3, P2^K4
    run_frame(3, 0);

    // zero length
    bus.frame_len = 16'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("zero_done_next", 32'(bus.done), 32'd1);
    check("zero_gen_rst", 32'(bus.gen_rst), 32'd0);
    check("zero_busy", 32'(bus.busy), 32'd0);
    tick();
    check("zero_done_one_cycle", 32'(bus.done), 32'd0);
    check("zero_state", 32'(state_o), 32'(S_IDLE));
    check("zero_busy_after", 32'({bus.busy, bus.gen_rst}), 32'd0);

    // backpressure until overflow
    bus.frame_len = 16'd10;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check("bp_warmup", 32'(state_o), 32'(S_WARMUP));
    send_key(5);
    send_key(6);
    check("bp_run", 32'(state_o), 32'(S_RUN));
    bus.pix_out_ready = 1'b1;
    bus.pix_in_valid = 1'b1;
    bus.pix_in = pix_tab[0];
    bus.key_valid = 1'b1;
    set_key(7);
    #1;
    check("bp_ready_empty", 32'(bus.pix_in_ready), 32'd0);
    tick();
    bus.key_valid = 1'b0;
    check("bp_ready_one", 32'(bus.pix_in_ready), 32'd1);
    tick();
    held = pix_tab[0] ^ key_tab[7];
    check("bp_first_out", 32'(bus.pix_out), 32'(held));
    bus.pix_out_ready = 1'b0;
    bus.pix_in = pix_tab[1];
    #1;
    check("bp_ready_stalled", 32'(bus.pix_in_ready), 32'd0);
    for (int i = 0; i < 20; i++) begin
      bus.key_valid = ((i >= 2) && (i <= 5)) || (i == 8);
      if (i == 8) set_key(12);
      else if (bus.key_valid) set_key(i + 6);
      tick();
      check("bp_pix_out_held", 32'(bus.pix_out), 32'(held));
      check("bp_valid_held", 32'(bus.pix_out_valid), 32'd1);
      check("bp_no_ready", 32'(bus.pix_in_ready), 32'd0);
      if (i == 5) begin
        check("bp_fifo_full", 32'(fifo_count_o), 32'd4);
        check("bp_no_err_yet", 32'(bus.err), 32'd0);
      end
      if (i == 8) begin
        check("bp_overflow_err", 32'(bus.err), 32'd1);
        check("bp_overflow_state", 32'(state_o), 32'(S_ERR));
      end
    end
    bus.key_valid = 1'b0;
    bus.pix_in_valid = 1'b0;
    bus.pix_out_ready = 1'b1;
    tick();
    check("err_pending_accepted", 32'(bus.pix_out_valid), 32'd0);
    check("err_no_ready", 32'(bus.pix_in_ready), 32'd0);
    check("err_held_state", 32'(state_o), 32'(S_ERR));
    check("err_sticky", 32'(bus.err), 32'd1);

    // recovery from ERR: single pixel uses third post-reseed triple (K15)
    run_frame(1, 13);

    // simultaneous push and pop at 3/4 occupancy
    bus.frame_len = 16'd5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    send_key(0);
    send_key(1);
    send_key(2);
    send_key(3);
    send_key(4);
    check("sim_occ3", 32'(fifo_count_o), 32'd3);
    for (int i = 1; i <= 4; i++) begin
      bus.key_valid = (i == 1);
      if (i == 1) set_key(5);
      bus.pix_in_valid = 1'b1;
      bus.pix_in = pix_tab[i];
      #1;
      check("sim_ready", 32'(bus.pix_in_ready), 32'd1);
      tick();
      bus.key_valid = 1'b0;
      if (i == 1) begin
        check("sim_occ_stays3", 32'(fifo_count_o), 32'd3);
        check("sim_no_err", 32'(bus.err), 32'd0);
      end
      check("sim_head_order", 32'(bus.pix_out), 32'(pix_tab[i] ^ key_tab[i + 1]));
    end
    bus.pix_in_valid = 1'b0;
    bus.pix_out_ready = 1'b0;

    // start ignored while busy, then async reset with pix_out_valid=1
    bus.frame_len = 16'd7;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("ignored_start_state", 32'(state_o), 32'(S_RUN));
    check("ignored_start_gen_rst", 32'(bus.gen_rst), 32'd0);
    check("pre_rst_valid", 32'(bus.pix_out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_state", 32'(state_o), 32'(S_IDLE));
    check("arst_pix_out_valid", 32'(bus.pix_out_valid), 32'd0);
    check("arst_pix_out", 32'(bus.pix_out), 32'd0);
    check("arst_ready_gen", 32'({bus.pix_in_ready, bus.gen_rst}), 32'd0);
    check("arst_flags", 32'({bus.done, bus.err, bus.busy}), 32'd0);
    check("arst_fifo", 32'(fifo_count_o), 32'd0);
    tick();
    rst = 1'b0;
    bus.pix_out_ready = 1'b1;
    repeat (3) begin
      tick();
      check("post_rst_idle", 32'(state_o), 32'(S_IDLE));
      check("post_rst_quiet", 32'({bus.busy, bus.gen_rst, bus.done, bus.pix_out_valid}), 32'd0);
    end

    // first start after reset behaves like any other
    run_frame(2, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/key_scheduler.md
KEY_SCHEDULER -- requirements
Module: key_scheduler

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, key-triple buffer depth, power of two, at least 2.
REQ-002 Parameter WARMUP_KEYS, default 2, key triples discarded after each reseed.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 start  input  1  one-cycle pulse; begins a frame.
REQ-006 frame_len  input  16  pixels in the frame; latched on an accepted start.
REQ-007 gen_rst  output  1  reset to the key generator; active-high.
REQ-008 key_valid  input  1  generator byte-ready pulse.
REQ-009 key_r, key_g, key_b  input  8 each  generator key bytes; valid when key_valid=1.
REQ-010 pix_in  input  24  pixel in; R is [23:16], G is [15:8], B is [7:0].
REQ-011 pix_in_valid / pix_in_ready  input / output  1 each  input handshake.
REQ-012 pix_out  output  24  pixel XOR key, using the same lane order as pix_in.
REQ-013 pix_out_valid / pix_out_ready  output / input  1 each  output handshake.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 done  output  1  one-cycle pulse at frame completion.
REQ-016 err  output  1  sticky key-overflow flag.

Function
REQ-017 States: IDLE, RESEED, WARMUP, RUN, DRAIN, ERR.
REQ-018 start is accepted only in IDLE or ERR; it is ignored in every other state.
- Accepted start: latch frame_len, flush the FIFO, clear err.
- frame_len=0: done pulses on the next cycle; state stays or returns to IDLE; gen_rst is not asserted.
- frame_len>0: go to RESEED.
REQ-019 RESEED: gen_rst=1 for exactly 2 cycles, then go to WARMUP; key_valid is ignored.
REQ-020 WARMUP: discard key_valid pulses; after the WARMUP_KEYS-th pulse, go to RUN; WARMUP_KEYS=0 goes straight to RUN.
REQ-021 RUN and DRAIN: each key_valid pushes {key_r,key_g,key_b} into the FIFO in the same cycle.
REQ-022 key_valid while the FIFO is full (before any same-cycle pop): drop the triple, set err=1, go to ERR.
REQ-023 A same-cycle pop does not prevent overflow; the full test uses occupancy at the start of the cycle.
REQ-024 pix_in_ready = (state==RUN) and FIFO not empty and (pix_out_valid==0 or pix_out_ready==1).
REQ-025 Input transfer (pix_in_valid and pix_in_ready):
- pix_out <= pix_in XOR FIFO head; pix_out_valid <= 1; pop the FIFO; decrement the remaining count.
- Latency is 1 cycle.
REQ-026 pix_out_valid clears on pix_out_ready when no new transfer occurs in that cycle; pix_out holds stable while valid and not ready.
REQ-027 Transfer of the last pixel (remaining count 1 -> 0): go to DRAIN.
REQ-028 DRAIN: pix_in_ready=0; when the output handshake completes, pulse done for 1 cycle and go to IDLE.
REQ-029 ERR: pix_in_ready=0.
- A pending pix_out stays valid until it is accepted.
- State is held until start or rst.
REQ-030 Key bytes are used in strict arrival order: the nth pixel of a frame uses the nth post-warmup triple.
REQ-031 FIFO pointers are log2(FIFO_DEPTH) bits plus one wrap bit; full = same index and different wrap bit.
REQ-032 The remaining-pixel counter is 16 bits and never decrements below 0.

Reset
REQ-033 rst asserted clears the following immediately:
- state=IDLE, FIFO empty, counters 0;
- gen_rst=0, pix_in_ready=0, pix_out_valid=0, pix_out=0;
- done=0, err=0, busy=0.
REQ-034 rst mid-frame abandons the frame; no done pulse is issued; there is no partial output afterwards.
REQ-035 The first accepted start after rst behaves identically to any other accepted start.

Verification
REQ-036 Nominal frame: frame_len=3, WARMUP_KEYS=2, key triples K1..K5 every 8 cycles, pixels always valid, pix_out_ready=1.
- gen_rst is high exactly 2 cycles.
- K1 and K2 are discarded.
- pix_out = P1^K3, P2^K4, P3^K5.
- done pulses once; busy then falls.
REQ-037 Backpressure: pix_out_ready=0 for 20 cycles mid-frame.
- pix_out is held stable.
- FIFO fills to 4; the 5th key_valid sets err and moves to ERR.
- No further pix_in_ready.
REQ-038 Zero length: start with frame_len=0.
- done is high on the next cycle only.
- gen_rst never rises; busy never rises.
REQ-039 Recovery: in ERR, start with frame_len=1.
- err clears; FIFO is flushed; full reseed and warmup occur.
- Output is the single pixel XOR the third post-reseed triple.
REQ-040 Async reset: rst asserted mid-RUN with pix_out_valid=1.
- All outputs are 0 before the next clk edge.
- A start ignored during busy is not remembered.
REQ-041 Simultaneous events: key_valid and pixel transfer in the same cycle with FIFO at 3/4.
- Occupancy stays 3.
- Head order is preserved.
- No err.
